// File: rtl/memory_access_pkg.sv
// Shared constants and small helpers for the MEM stage: access-size encodings,
// link register index, byte-lane enables and alignment rules.
package memory_access_pkg;

  localparam logic [1:0] SIZE_BYTE     = 2'b00;
  localparam logic [1:0] SIZE_HALF     = 2'b01;
  localparam logic [1:0] SIZE_WORD     = 2'b11;
  localparam logic [4:0] LINK_REGISTER = 5'd31;

  // Lanes touched by an access; the reserved size 2'b10 behaves as a word.
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: lane_enable = 4'b0001 << lane;
      SIZE_HALF: lane_enable = lane[1] ? 4'b1100 : 4'b0011;
      default:   lane_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: is_aligned = 1'b1;
      SIZE_HALF: is_aligned = ~lane[0];
      default:   is_aligned = (lane == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/memory_access_data_memory.sv
// Byte-lane-enabled word array: synchronous write and clear, combinational
// access and debug read ports.
module data_memory #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDRESS = 7
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_write_enable,
  input  logic [NB_DATA/8-1:0]    i_byte_enable,
  input  logic [NB_ADDRESS-1:0]   i_address,
  input  logic [NB_DATA-1:0]      i_write_data,
  output logic [NB_DATA-1:0]      o_read_data,
  input  logic [NB_ADDRESS-1:0]   i_debug_address,
  output logic [NB_DATA-1:0]      o_debug_data
);

  localparam int NB_WORDS = 32'd1 << NB_ADDRESS;

  logic [NB_DATA-1:0] mem_r [NB_WORDS];

  // Clear on reset takes priority, so a store in the reset cycle is lost.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int w = 0; w < NB_WORDS; w++) begin
        mem_r[w] <= {NB_DATA{1'b0}};
      end
    end else if (i_write_enable) begin
      for (int b = 0; b < NB_DATA/8; b++) begin
        if (i_byte_enable[b]) begin
          mem_r[i_address][8*b +: 8] <= i_write_data[8*b +: 8];
        end
      end
    end
  end

  assign o_read_data  = mem_r[i_address];
  assign o_debug_data = mem_r[i_debug_address];

endmodule

// File: rtl/memory_access.sv
// MEM stage: sized loads/stores against data_memory, alignment fault tracking,
// write-back source selection and the MEM/WB pipeline register.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int NB_DATA        = 32,
  parameter int NB_REG_ADDRESS = 5,
  parameter int NB_MEM_ADDRESS = 7
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [NB_DATA-1:0]        i_alu_result,
  input  logic [NB_DATA-1:0]        i_write_data,
  input  logic [NB_DATA-1:0]        i_return_address,
  input  logic [NB_REG_ADDRESS-1:0] i_dest_register,
  input  logic                      i_mem_read,
  input  logic                      i_mem_write,
  input  logic                      i_mem_to_reg,
  input  logic                      i_reg_write,
  input  logic                      i_jump_return_dest,
  input  logic [1:0]                i_access_size,
  input  logic                      i_load_unsigned,
  input  logic [NB_MEM_ADDRESS-1:0] i_debug_address,
  output logic [NB_DATA-1:0]        o_debug_data,
  output logic [NB_DATA-1:0]        o_data_write_back,
  output logic [NB_REG_ADDRESS-1:0] o_dest_register,
  output logic                      o_jump_return_dest,
  output logic                      o_reg_write,
  output logic                      o_misaligned
);

  logic [NB_MEM_ADDRESS-1:0] word_index_s;
  logic [1:0]                lane_s;
  logic                      aligned_s;
  logic                      store_en_s;
  logic                      misaligned_set_s;
  logic [3:0]                byte_en_s;
  logic [NB_DATA-1:0]        store_data_s;
  logic [NB_DATA-1:0]        mem_word_s;
  logic [7:0]                load_byte_s;
  logic [15:0]               load_half_s;
  logic [NB_DATA-1:0]        load_data_s;
  logic [NB_DATA-1:0]        write_back_s;

  logic [NB_DATA-1:0]        data_write_back_r;
  logic [NB_REG_ADDRESS-1:0] dest_register_r;
  logic                      jump_return_dest_r;
  logic                      reg_write_r;
  logic                      misaligned_r;

  assign word_index_s     = i_alu_result[NB_MEM_ADDRESS+1:2];
  assign lane_s           = i_alu_result[1:0];
  assign aligned_s        = is_aligned(i_access_size, lane_s);
  assign byte_en_s        = lane_enable(i_access_size, lane_s);
  assign store_en_s       = i_enable & i_mem_write & aligned_s;
  assign misaligned_set_s = i_enable & (i_mem_read | i_mem_write) & ~aligned_s;
  assign load_byte_s      = mem_word_s[{lane_s, 3'b000} +: 8];
  assign load_half_s      = mem_word_s[{lane_s[1], 4'b0000} +: 16];

  data_memory #(
    .NB_DATA    (NB_DATA),
    .NB_ADDRESS (NB_MEM_ADDRESS)
  ) u_data_memory (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_write_enable  (store_en_s),
    .i_byte_enable   (byte_en_s),
    .i_address       (word_index_s),
    .i_write_data    (store_data_s),
    .o_read_data     (mem_word_s),
    .i_debug_address (i_debug_address),
    .o_debug_data    (o_debug_data)
  );

  // Store data is replicated across lanes; the lane enables pick the target bytes.
  always_comb begin
    store_data_s = i_write_data;
    case (i_access_size)
      SIZE_BYTE: store_data_s = {(NB_DATA/8){i_write_data[7:0]}};
      SIZE_HALF: store_data_s = {(NB_DATA/16){i_write_data[15:0]}};
      default:   store_data_s = i_write_data;
    endcase
  end

  // Lane extraction and extension; a misaligned access reads as zero.
  always_comb begin
    load_data_s = {NB_DATA{1'b0}};
    if (aligned_s) begin
      case (i_access_size)
        SIZE_BYTE: load_data_s = i_load_unsigned ? {{(NB_DATA-8){1'b0}}, load_byte_s}
                                                 : {{(NB_DATA-8){load_byte_s[7]}}, load_byte_s};
        SIZE_HALF: load_data_s = i_load_unsigned ? {{(NB_DATA-16){1'b0}}, load_half_s}
                                                 : {{(NB_DATA-16){load_half_s[15]}}, load_half_s};
        default:   load_data_s = mem_word_s;
      endcase
    end else begin
      load_data_s = {NB_DATA{1'b0}};
    end
  end

  // Write-back source: link value beats load data beats ALU result.
  always_comb begin
    write_back_s = i_alu_result;
    if (i_jump_return_dest) begin
      write_back_s = i_return_address;
    end else if (i_mem_to_reg) begin
      write_back_s = load_data_s;
    end else begin
      write_back_s = i_alu_result;
    end
  end

  // MEM/WB pipeline register, frozen while the pipeline is stalled.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      data_write_back_r  <= {NB_DATA{1'b0}};
      dest_register_r    <= {NB_REG_ADDRESS{1'b0}};
      jump_return_dest_r <= 1'b0;
      reg_write_r        <= 1'b0;
    end else if (i_enable) begin
      data_write_back_r  <= write_back_s;
      dest_register_r    <= i_dest_register;
      jump_return_dest_r <= i_jump_return_dest;
      reg_write_r        <= i_reg_write;
    end
  end

  // Sticky alignment fault, cleared only by reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      misaligned_r <= 1'b0;
    end else if (misaligned_set_s) begin
      misaligned_r <= 1'b1;
    end
  end

  assign o_data_write_back  = data_write_back_r;
  assign o_dest_register    = dest_register_r;
  assign o_jump_return_dest = jump_return_dest_r;
  assign o_reg_write        = reg_write_r;
  assign o_misaligned       = misaligned_r;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: byte-array reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        i_reset, i_enable;
  logic [31:0] i_alu_result, i_write_data, i_return_address;
  logic [4:0]  i_dest_register;
  logic        i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write, i_jump_return_dest;
  logic [1:0]  i_access_size;
  logic        i_load_unsigned;
  logic [6:0]  i_debug_address;
  logic [31:0] o_debug_data, o_data_write_back;
  logic [4:0]  o_dest_register;
  logic        o_jump_return_dest, o_reg_write, o_misaligned;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  memory_access dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_alu_result(i_alu_result), .i_write_data(i_write_data),
    .i_return_address(i_return_address), .i_dest_register(i_dest_register),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
    .i_reg_write(i_reg_write), .i_jump_return_dest(i_jump_return_dest),
    .i_access_size(i_access_size), .i_load_unsigned(i_load_unsigned),
    .i_debug_address(i_debug_address), .o_debug_data(o_debug_data),
    .o_data_write_back(o_data_write_back), .o_dest_register(o_dest_register),
    .o_jump_return_dest(o_jump_return_dest), .o_reg_write(o_reg_write),
    .o_misaligned(o_misaligned)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: 512-byte little-endian memory plus expected register values.
  logic [7:0]  mm [512];
  logic [31:0] m_wb;
  logic [4:0]  m_dest;
  logic        m_jal, m_rw, m_mis;
  int          ma, mn;
  logic [31:0] mld;
  bit          mbad;

  function automatic logic [31:0] model_word(input int idx);
    return {mm[4*idx+3], mm[4*idx+2], mm[4*idx+1], mm[4*idx]};
  endfunction

  always @(posedge clk) begin
    if (i_reset) begin
      for (int k = 0; k < 512; k++) mm[k] = 8'h00;
      m_wb = 32'h0; m_dest = 5'h0; m_jal = 1'b0; m_rw = 1'b0; m_mis = 1'b0;
    end else if (i_enable) begin
      ma   = int'(i_alu_result[8:0]);
      mn   = (i_access_size == 2'b00) ? 1 : (i_access_size == 2'b01) ? 2 : 4;
      mbad = (ma % mn) != 0;
      mld  = 32'h0;
      if (!mbad) begin
        for (int k = 0; k < mn; k++) mld = mld | (32'(mm[ma+k]) << (8*k));
        if (mn == 1 && !i_load_unsigned && mld[7])  mld = mld | 32'hFFFFFF00;
        if (mn == 2 && !i_load_unsigned && mld[15]) mld = mld | 32'hFFFF0000;
      end
      m_wb   = i_jump_return_dest ? i_return_address : i_mem_to_reg ? mld : i_alu_result;
      m_dest = i_dest_register;
      m_jal  = i_jump_return_dest;
      m_rw   = i_reg_write;
      if (i_mem_write && !mbad)
        for (int k = 0; k < mn; k++) mm[ma+k] = i_write_data[8*k +: 8];
      if ((i_mem_read || i_mem_write) && mbad) m_mis = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("wb",    o_data_write_back, m_wb);
      chk("dest",  {27'd0, o_dest_register}, {27'd0, m_dest});
      chk("jal",   {31'd0, o_jump_return_dest}, {31'd0, m_jal});
      chk("rw",    {31'd0, o_reg_write}, {31'd0, m_rw});
      chk("mis",   {31'd0, o_misaligned}, {31'd0, m_mis});
      chk("debug", o_debug_data, model_word(int'(i_debug_address)));
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic jal, input logic [1:0] sz, input logic uns,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] ret,
                       input logic [4:0] dst, input logic [6:0] dbg);
    i_mem_read = rd; i_mem_write = wr; i_mem_to_reg = m2r; i_reg_write = rw;
    i_jump_return_dest = jal; i_access_size = sz; i_load_unsigned = uns;
    i_alu_result = alu; i_write_data = wd; i_return_address = ret;
    i_dest_register = dst; i_debug_address = dbg;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 7'd0);
    cycle(); cycle();
    chk_on = 1'b1;
    chk("reset_wb",  o_data_write_back, 32'h0);
    chk("reset_mis", {31'd0, o_misaligned}, 32'h0);
    i_reset = 1'b0;

    // Word store then load
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 5'd0, 7'd4); cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 5'd3, 7'd4); cycle();
    chk("lw_dead",  o_data_write_back, 32'hDEADBEEF);
    chk("dbg_dead", o_debug_data, 32'hDEADBEEF);

    // Byte and half lanes over a cleared word
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 5'd0, 7'd4); cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h12345680, 32'h0, 5'd0, 7'd4); cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0, 5'd2, 7'd4); cycle();
    chk("lb", o_data_write_back, 32'hFFFFFF80);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0, 5'd2, 7'd4); cycle();
    chk("lbu", o_data_write_back, 32'h00000080);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'hAAAA8001, 32'h0, 5'd0, 7'd4); cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0, 5'd6, 7'd4); cycle();
    chk("lh", o_data_write_back, 32'hFFFF8001);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 5'd6, 7'd4); cycle();
    chk("lw_mix", o_data_write_back, 32'h80010000);

    // Misalignment: suppressed store, zero load, sticky flag
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h11, 32'hFFFFFFFF, 32'h0, 5'd0, 7'd4); cycle();
    chk("mis_set",  {31'd0, o_misaligned}, 32'h1);
    chk("mis_keep", o_debug_data, 32'h80010000);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 5'd7, 7'd4); cycle();
    chk("mis_lh", o_data_write_back, 32'h0);

    // Write-back mux
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 32'h48, 5'd31, 7'd4); cycle();
    chk("jal_wb",   o_data_write_back, 32'h48);
    chk("jal_flag", {31'd0, o_jump_return_dest}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd5, 7'd4); cycle();
    chk("alu_wb", o_data_write_back, 32'h1234);
    chk("mis_sticky", {31'd0, o_misaligned}, 32'h1);

    // Freeze, then commit
    i_enable = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 5'd9, 7'd8); cycle();
    chk("frz_mem", o_debug_data, 32'h0);
    chk("frz_wb",  o_data_write_back, 32'h1234);
    i_enable = 1'b1;
    cycle();
    chk("frz_commit", o_debug_data, 32'hCAFEF00D);

    // Read-before-write, debug collision
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h11112222, 32'h0, 5'd4, 7'd8);
    #1;
    chk("coll_old", o_debug_data, 32'hCAFEF00D);
    cycle();
    chk("rbw_wb",   o_data_write_back, 32'hCAFEF00D);
    chk("coll_new", o_debug_data, 32'h11112222);

    // Address wrap
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h200, 32'h000055AA, 32'h0, 5'd0, 7'd0); cycle();
    chk("wrap", o_debug_data, 32'h000055AA);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h7C, 32'h00000077, 32'h0, 5'd0, 7'd31); cycle();
    chk("size10", o_debug_data, 32'h00000077);

    // Reset with a store presented
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'h24, 32'h99, 32'h44, 5'd8, 7'd9);
    i_reset = 1'b1;
    cycle();
    chk("rst_wb",  o_data_write_back, 32'h0);
    chk("rst_rw",  {31'd0, o_reg_write}, 32'h0);
    chk("rst_mis", {31'd0, o_misaligned}, 32'h0);
    i_reset = 1'b0;
    i_enable = 1'b0;
    for (int i = 0; i < 128; i++) begin
      i_debug_address = 7'(i);
      #1;
      chk("rst_mem", o_debug_data, 32'h0);
    end
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the 5-stage MIPS pipeline, sitting between the EX/MEM register and the write_back stage.
- Performs byte, halfword and word loads and stores against an internal byte-addressed data memory.
- Selects the value to be written back from load data, ALU result or return address, and registers it in the MEM/WB pipeline register that feeds write_back.
- Provides a combinational debug read port for the debug unit's memory dump.

Parameters:
- NB_DATA, 32, data/word width.
- NB_REG_ADDRESS, 5, register-file address width.
- NB_MEM_ADDRESS, 7, word-index width; memory holds 2^NB_MEM_ADDRESS words.

Ports:
- i_clock  in  1  pipeline clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  pipeline advance (debug step/run); low = stage frozen.
- i_alu_result  in  NB_DATA  effective address, or the ALU value for R/I-type ops.
- i_write_data  in  NB_DATA  rt value to store.
- i_return_address  in  NB_DATA  link value for JAL/JALR.
- i_dest_register  in  NB_REG_ADDRESS  destination register.
- i_mem_read  in  1  load.
- i_mem_write  in  1  store.
- i_mem_to_reg  in  1  write-back source is load data.
- i_reg_write  in  1  instruction writes the register file.
- i_jump_return_dest  in  1  JAL-type link.
- i_access_size  in  2  00 = byte, 01 = half, 11 = word; 10 is treated as word.
- i_load_unsigned  in  1  zero-extend (LBU/LHU).
- i_debug_address  in  NB_MEM_ADDRESS  debug word index.
- o_debug_data  out  NB_DATA  memory word at i_debug_address, combinational.
- o_data_write_back  out  NB_DATA  registered write-back data.
- o_dest_register  out  NB_REG_ADDRESS  registered destination.
- o_jump_return_dest  out  1  registered link flag.
- o_reg_write  out  1  registered write enable.
- o_misaligned  out  1  sticky alignment-fault flag.

Behaviour:
- **Addressing.** Word index = i_alu_result[NB_MEM_ADDRESS+1:2]. Upper address bits are ignored, so addresses wrap modulo memory size. Byte lane = i_alu_result[1:0], little-endian (lane 0 = bits 7:0).
- **Stores.** Occur at the rising edge when i_enable & i_mem_write & aligned.
  - Byte: writes lane a[1:0] with i_write_data[7:0].
  - Half: writes lanes {a[1],0} and {a[1],1} with i_write_data[15:0].
  - Word: writes the full word.
  - Unaddressed lanes are preserved.
- **Loads.** Read the memory array combinationally in the same cycle.
  - Byte/half data is extracted from the addressed lane(s).
  - Sign-extended unless i_load_unsigned; word loads ignore i_load_unsigned.
- **Alignment.** Half requires a[0] = 0; word requires a[1:0] = 0.
  - A misaligned store is suppressed.
  - A misaligned load returns 0.
  - Either case sets o_misaligned, which holds until reset.
- **Write-back mux priority.**
  - i_jump_return_dest → i_return_address.
  - else i_mem_to_reg → load data.
  - else i_alu_result.
- **MEM/WB register.** When i_enable is high, o_data_write_back, o_dest_register, o_jump_return_dest and o_reg_write capture their next values at the rising edge. Latency is 1 cycle from stage inputs to outputs.
- **Freeze.** When i_enable is low, outputs hold, no store occurs and o_misaligned does not update. Debug reads remain valid.
- **Simultaneous read and write.** i_mem_read & i_mem_write in the same cycle is read-before-write: the load returns the pre-store contents and the store commits at the edge.
- **Debug/store collision.** A debug read at the address being stored returns old data in that cycle and new data from the next cycle.
- **Reset.**
  - All registered outputs go to 0 and o_misaligned goes to 0.
  - All memory words are cleared to 0.
  - Reset overrides i_enable.
  - A store presented in the reset cycle is discarded.
- **Store output.** A store with i_reg_write = 0 still advances the pipeline register; o_reg_write = 0.

Decomposition:
- Shared package constants:
  - Access-size encodings SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b11.
  - Link register index 31, shared with write_back.
- One natural sub-module, data_memory: byte-lane-enabled word array with synchronous write, synchronous clear, one combinational read port and one debug read port.
- Lane extraction, extension, alignment check and write-back mux stay in memory_access.

Test Plan:
- **Word store/load.** SW 0xDEADBEEF at addr 0x10, then LW at 0x10 with mem_to_reg → o_data_write_back = 0xDEADBEEF one cycle after the load; o_debug_data at index 4 = 0xDEADBEEF.
- **Byte/half lanes.** SB 0x80 at 0x13 over word 0x00000000, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; SH 0x8001 at 0x12, then LH 0x12 → 0xFFFF8001; LW 0x10 → 0x80010000.
- **Misalignment.** SW at 0x11 → memory unchanged, o_misaligned = 1 next cycle and stays 1. LH at 0x13 → o_data_write_back = 0.
- **Write-back mux.** JAL with return address 0x00000048 and mem_to_reg = 1 → o_data_write_back = 0x48 and o_jump_return_dest = 1. ALU op with 0x1234 and mem_to_reg = 0 → 0x1234.
- **Freeze.** i_enable = 0 with a SW presented → memory unchanged and outputs held; raising i_enable commits the store.
- **Reset and wrap.**
  - Assert i_reset after several stores → all debug reads = 0, outputs = 0, o_misaligned = 0.
  - SW at 0x200 with NB_MEM_ADDRESS = 7 → lands in word 0.
